// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter between NUM_REQ byte producers.
// Optional grant locking for multi-byte messages: define UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ID_WIDTH     = 2,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    reqValid,
  input  logic [8*NUM_REQ-1:0]  reqData,
  input  logic [NUM_REQ-1:0]    reqLock,
  output logic [NUM_REQ-1:0]    reqAck,
  output logic [7:0]            uartData,
  output logic                  uartDataReady,
  input  logic                  uartBusy,
  output logic [ID_WIDTH-1:0]   grantId,
  output logic                  arbBusy,
  output logic                  timeoutErr
);

  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t state, state_n;

  logic [NUM_REQ-1:0][7:0] req_bytes;
  logic [NUM_REQ-1:0]      cand;
  logic [CW-1:0]           cnt, cnt_n;
  logic                    timeout_hit;

  logic                    win_found, hi_f, lo_f;
  logic [ID_WIDTH-1:0]     win, hi, lo;
  logic [NUM_REQ-1:0]      win_oh, hi_oh, lo_oh;
  logic [7:0]              win_data;

  logic [NUM_REQ-1:0]      ack_n;
  logic                    rdy_n, err_n;
  logic [7:0]              data_n;
  logic [ID_WIDTH-1:0]     gid_n;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_bytes[g] = reqData[8*g +: 8];
  end

`ifdef UART_ARB_LOCK_EN
  logic [NUM_REQ-1:0] lock_oh, lock_n;
  logic               hold;

  // The owner keeps exclusive access only while its own lock bit stays high.
  assign hold = |(lock_oh & reqLock);
  assign cand = hold ? (reqValid & lock_oh) : reqValid;

  always_comb begin
    lock_n = lock_oh;
    if (state == IDLE && !hold) lock_n = '0;
    if (state == WAIT_BUSY && |reqAck) lock_n = reqAck & reqLock;
    if (timeout_hit) lock_n = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lock_oh <= '0;
    else       lock_oh <= lock_n;
  end
`else
  logic unused_lock;
  assign unused_lock = ^reqLock;
  assign cand        = reqValid;
`endif

  // Two-sided priority: lowest index above grantId wins, else lowest index at or below it.
  always_comb begin
    hi_f     = 1'b0;
    lo_f     = 1'b0;
    hi       = '0;
    lo       = '0;
    hi_oh    = '0;
    lo_oh    = '0;
    win_data = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        if (i > int'(grantId)) begin
          hi_f  = 1'b1;
          hi    = ID_WIDTH'(i);
          hi_oh = NUM_REQ'(1) << i;
        end else begin
          lo_f  = 1'b1;
          lo    = ID_WIDTH'(i);
          lo_oh = NUM_REQ'(1) << i;
        end
      end
    end
    win_found = hi_f | lo_f;
    win       = hi_f ? hi : lo;
    win_oh    = hi_f ? hi_oh : lo_oh;
    for (int i = 0; i < NUM_REQ; i++)
      if (win_oh[i]) win_data = win_data | req_bytes[i];
  end

  assign timeout_hit = (state == WAIT_BUSY) && !uartBusy && (cnt == CW'(BUSY_TIMEOUT - 1));
  assign arbBusy     = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (win_found) state_n = WAIT_BUSY;
      WAIT_BUSY: if (uartBusy) state_n = WAIT_DONE;
                 else if (timeout_hit) state_n = IDLE;
      WAIT_DONE: if (!uartBusy) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_comb begin
    ack_n  = '0;
    rdy_n  = 1'b0;
    data_n = uartData;
    gid_n  = grantId;
    cnt_n  = cnt;
    err_n  = timeoutErr;
    case (state)
      IDLE: if (win_found) begin
        ack_n  = win_oh;
        rdy_n  = 1'b1;
        data_n = win_data;
        gid_n  = win;
        cnt_n  = '0;
      end
      WAIT_BUSY: if (!uartBusy) begin
        cnt_n = cnt + CW'(1);
        if (timeout_hit) err_n = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reqAck        <= '0;
      uartDataReady <= 1'b0;
      uartData      <= 8'h00;
      grantId       <= ID_WIDTH'(NUM_REQ - 1);
      cnt           <= '0;
      timeoutErr    <= 1'b0;
    end else begin
      reqAck        <= ack_n;
      uartDataReady <= rdy_n;
      uartData      <= data_n;
      grantId       <= gid_n;
      cnt           <= cnt_n;
      timeoutErr    <= err_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: a transaction-level arbitration model is
// checked against every DUT output each cycle; a simple transmitter model drives uartBusy.
module tb_uart_tx_arbiter;
  localparam int N = 4, IW = 2, T = 15, FRAME = 20;

  logic            clk = 1'b0, reset;
  logic [N-1:0]    req_valid, req_lock, req_ack;
  logic [8*N-1:0]  req_data;
  logic [7:0]      uart_data;
  logic            uart_rdy, uart_busy, arb_busy, timeout_err;
  logic [IW-1:0]   grant_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .ID_WIDTH(IW), .BUSY_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .reqValid(req_valid), .reqData(req_data),
    .reqLock(req_lock), .reqAck(req_ack), .uartData(uart_data),
    .uartDataReady(uart_rdy), .uartBusy(uart_busy), .grantId(grant_id),
    .arbBusy(arb_busy), .timeoutErr(timeout_err));

  int vectors = 0, miscompares = 0;

  // reference model: 0 idle, 1 waiting for busy rise, 2 waiting for frame end
  int          m_phase, m_gid, m_cnt, m_lock;
  bit          m_err, m_first;
  logic [7:0]  m_data;
  logic [N-1:0] m_ack;

  // stimulus state
  int          mode, start_in = -1, busy_left = 0;
  bit          tx_dead = 0, cont = 0, alt = 0;
  logic [N-1:0] mask;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_gid = N - 1; m_cnt = 0; m_lock = -1;
    m_err = 0; m_first = 0; m_data = 8'h00; m_ack = '0;
  endtask

  // Winner = pending requester at the smallest circular distance after the last grant.
  task automatic model_step();
    logic [N-1:0] c;
    int best, bestd, d;
    m_ack = '0;
    case (m_phase)
      0: begin
`ifdef UART_ARB_LOCK_EN
        if (m_lock >= 0 && !req_lock[m_lock]) m_lock = -1;
        c = (m_lock >= 0) ? (req_valid & (N'(1) << m_lock)) : req_valid;
`else
        c = req_valid;
`endif
        best = -1; bestd = N;
        for (int i = 0; i < N; i++)
          if (c[i]) begin
            d = (i - m_gid - 1 + 2 * N) % N;
            if (d < bestd) begin bestd = d; best = i; end
          end
        if (best >= 0) begin
          m_ack[best] = 1'b1;
          m_data  = req_data[8*best +: 8];
          m_gid   = best;
          m_cnt   = 0;
          m_phase = 1;
          m_first = 1;
        end
      end
      1: begin
`ifdef UART_ARB_LOCK_EN
        if (m_first) m_lock = req_lock[m_gid] ? m_gid : -1;
`endif
        m_first = 0;
        if (uart_busy) m_phase = 2;
        else begin
          m_cnt++;
          if (m_cnt == T) begin m_err = 1; m_phase = 0; m_lock = -1; end
        end
      end
      default: if (!uart_busy) m_phase = 0;
    endcase
  endtask

  task automatic check_outputs();
    chk("ack",   32'(req_ack),     32'(m_ack));
    chk("rdy",   32'(uart_rdy),    32'(|m_ack));
    chk("data",  32'(uart_data),   32'(m_data));
    chk("gid",   32'(grant_id),    32'(m_gid));
    chk("abusy", 32'(arb_busy),    32'(m_phase != 0));
    chk("terr",  32'(timeout_err), 32'(m_err));
  endtask

  function automatic logic [7:0] next_byte(input int i);
    case (mode)
      0: next_byte = 8'h41;
      1: next_byte = 8'h30 + 8'(i);
      3: begin next_byte = alt ? 8'h55 : 8'hAA; alt = ~alt; end
      default: next_byte = 8'($urandom);
    endcase
  endfunction

  task automatic drive_step();
    if (uart_rdy && !tx_dead) start_in = $urandom_range(2, 0);
    if (start_in == 0) begin busy_left = FRAME; start_in = -1; end
    else if (start_in > 0) start_in--;
    uart_busy = (busy_left > 0);
    if (busy_left > 0) busy_left--;
    for (int i = 0; i < N; i++) begin
      if (req_ack[i]) begin
        if (cont || $urandom_range(1, 0) == 1) req_data[8*i +: 8] = next_byte(i);
        else req_valid[i] = 1'b0;
      end else if (!req_valid[i] && mask[i] && $urandom_range(3, 0) == 0) begin
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = next_byte(i);
      end
      if ($urandom_range(15, 0) == 0) req_lock[i] = ~req_lock[i];
    end
  endtask

  task automatic run(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      model_step();
      #1;
      check_outputs();
      drive_step();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    repeat (3) begin
      @(posedge clk);
      #1;
      check_outputs();
      drive_step();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_data = '0; req_lock = '0; uart_busy = 1'b0;
    mode = 0; mask = 4'b0100;
    model_reset();
    #2 check_outputs();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    mode = 0; mask = 4'b0100; cont = 0;
    run(200);

    mode = 1; mask = 4'b1111; cont = 1;
    run(300);

    // async reset while a frame is in flight
    begin
      int k = 0;
      while (m_phase != 2 && k < 100) begin run(1); k++; end
      if (m_phase != 2) chk("reach_wait_done", 32'(m_phase), 32'd2);
    end
    run(3);
    do_reset();

    mode = 2; mask = 4'b1111; cont = 0; tx_dead = 1;
    run(300);
    tx_dead = 0;

    mode = 3; mask = 4'b1000; cont = 1; alt = 0;
    run(300);

    mode = 4; mask = 4'b1111; cont = 0;
    repeat (6) begin
      run(500);
      mask = 4'($urandom_range(15, 1));
      tx_dead = ($urandom_range(5, 0) == 0);
    end
    tx_dead = 0;
    run(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one 8N1 UART transmitter between NUM_REQ byte producers, e.g. debug printer, status reporter and command echo.
- Round-robin arbitration over per-requester valid/ack handshakes.
- Drives the transmitter's data / dataReady / busy interface, one byte at a time, and waits for frame completion before re-arbitrating.
- Sits directly between the producers and the transmitter instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_WIDTH, 2, width of grantId; must satisfy 2**ID_WIDTH >= NUM_REQ
BUSY_TIMEOUT, 15, cycles to wait in WAIT_BUSY for the UART busy rise before abandoning the byte

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
reqValid  in  NUM_REQ  requester i has a byte pending; held until its ack
reqData  in  8*NUM_REQ  byte for requester i at bits [8i+7:8i]; stable while reqValid[i] high
reqLock  in  NUM_REQ  keep grant for multi-byte messages (used only with UART_ARB_LOCK_EN)
reqAck  out  NUM_REQ  one-hot, one-cycle pulse: byte from requester i accepted
uartData  out  8  byte to transmitter
uartDataReady  out  1  one-cycle start pulse to transmitter
uartBusy  in  1  transmitter busy flag
grantId  out  ID_WIDTH  index of last granted requester
arbBusy  out  1  high whenever state != IDLE
timeoutErr  out  1  sticky; set on busy timeout, cleared only by reset

Behaviour:
- Single clk domain. All outputs registered except arbBusy, which decodes state.
- Reset (async, any time, including mid-frame):
  - state=IDLE, reqAck=0, uartDataReady=0, uartData=8'h00.
  - grantId=NUM_REQ-1, so requester 0 has first priority.
  - timeoutErr=0, timeout counter=0, lock owner cleared.
  - The transmitter is not otherwise informed.
- States: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - On an edge with any reqValid high, pick winner w = first set bit searching grantId+1, grantId+2, ... modulo NUM_REQ.
  - Register uartData<=reqData[w], uartDataReady<=1, reqAck<=onehot(w), grantId<=w, counter<=0; go to WAIT_BUSY.
  - Result: ack and dataReady are both high in the cycle after the sampling edge (latency 1), for exactly one cycle.
- WAIT_BUSY:
  - uartDataReady and reqAck return to 0.
  - uartBusy=1 -> WAIT_DONE.
  - Otherwise counter increments; when counter reaches BUSY_TIMEOUT, set timeoutErr and go to IDLE. The byte is dropped, not retried.
- WAIT_DONE: uartBusy=0 -> IDLE.
- reqValid is ignored outside IDLE. The minimum gap between consecutive acks is one full frame plus 1 idle cycle.
- A requester may keep reqValid high on its ack cycle and present the next byte; it is re-arbitrated normally and does not get back-to-back priority over others.
- Single requester pending: it wins every arbitration regardless of grantId.
- reqValid bits whose index >= NUM_REQ do not exist. Wrap-around: after grantId=NUM_REQ-1 the search starts at 0.

Optional Feature:
Macro UART_ARB_LOCK_EN.
- Defined:
  - A winner whose reqLock[w] is high at its ack cycle becomes lock owner.
  - While the owner's reqLock stays high, IDLE considers only the owner. The arbiter waits in IDLE even if the owner's valid is low and others are pending.
  - Lock is released when the owner's reqLock is sampled low in IDLE; normal round-robin resumes from the owner's index.
  - A timeout also releases the lock.
- Undefined: reqLock is ignored, pure round-robin, no owner register synthesised.

Test Plan:
1. Reset mid-frame: assert reset 3 cycles while in WAIT_DONE -> reqAck=0, uartDataReady=0, grantId=3, arbBusy=0 immediately; next request is granted normally.
2. Single requester: reqValid=4'b0100, reqData[23:16]=8'h41 -> one cycle later reqAck=4'b0100, uartDataReady=1, uartData=8'h41; tx line carries 0x41 at 9600 baud; arbBusy falls one cycle after uartBusy falls.
3. All four valid continuously, bytes 8'h30..8'h33 -> ack order 0,1,2,3,0,... with exactly one ack per UART frame; transmitted stream "0123".
4. Busy never rises (transmitter held in reset) -> after BUSY_TIMEOUT=15 cycles in WAIT_BUSY, timeoutErr=1 and state=IDLE; next request is still served; timeoutErr stays 1.
5. Lock (UART_ARB_LOCK_EN): req1 sends 3 bytes with reqLock[1]=1 while req0 and req2 are valid -> all three req1 bytes are sent contiguously; after reqLock[1] drops, req2 is granted next, then req0. Without the macro the bytes interleave 1,2,0,1,...
6. Requester re-presents on its ack cycle with only req3 active: bytes 8'hAA then 8'h55 -> two acks, gap = frame length + 1 cycle, both bytes transmitted in order.
